// File: rtl/inv_mixcolumn_module.sv
`default_nettype none
// ============================================================================
// Module   : inv_mixcolumn_module
// Brief    : Iterative AES InvMixColumns engine, one column per clock,
//            results published together with a single-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module inv_mixcolumn_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] statew1,
    input  logic [31:0] statew2,
    input  logic [31:0] statew3,
    input  logic [31:0] statew4,
    output logic        done,
    output logic [31:0] new_statew1,
    output logic [31:0] new_statew2,
    output logic [31:0] new_statew3,
    output logic [31:0] new_statew4
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_col;
    logic [31:0] r_in  [0:3];
    logic [31:0] r_res [0:3];
    logic [31:0] r_out [0:3];
    logic        r_done;
    logic [31:0] w_col_in;
    logic [31:0] w_col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [0:3];
        logic [7:0] m9 [0:3];
        logic [7:0] mb [0:3];
        logic [7:0] md [0:3];
        logic [7:0] me [0:3];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // One shared column datapath, fed by the column selected by the counter
    assign w_col_in  = r_in[r_col];
    assign w_col_out = inv_mix_col(w_col_in);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_col == 2'd3) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_HOLD : S_IDLE;
            S_HOLD:  if (!start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= 2'd0;
            r_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_in[i]  <= 32'h0;
                r_res[i] <= 32'h0;
                r_out[i] <= 32'h0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in[0] <= statew1;
                        r_in[1] <= statew2;
                        r_in[2] <= statew3;
                        r_in[3] <= statew4;
                        r_col   <= 2'd0;
                    end
                end
                S_BUSY: begin
                    r_res[r_col] <= w_col_out;
                    r_col        <= r_col + 2'd1;
                end
                S_DONE: begin
                    for (int i = 0; i < 4; i++) r_out[i] <= r_res[i];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done        = r_done;
    assign new_statew1 = r_out[0];
    assign new_statew2 = r_out[1];
    assign new_statew3 = r_out[2];
    assign new_statew4 = r_out[3];

endmodule
`default_nettype wire

// File: tb/tb_inv_mixcolumn_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_mixcolumn_module
// Brief    : Directed self-checking bench for inv_mixcolumn_module.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_mixcolumn_module;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] statew1 = '0, statew2 = '0, statew3 = '0, statew4 = '0;
    logic        done;
    logic [31:0] new_statew1, new_statew2, new_statew3, new_statew4;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int dbl_cnt = 0;
    logic prev_done = 1'b0;

    inv_mixcolumn_module dut (
        .clk(clk), .rst(rst), .start(start),
        .statew1(statew1), .statew2(statew2), .statew3(statew3), .statew4(statew4),
        .done(done),
        .new_statew1(new_statew1), .new_statew2(new_statew2),
        .new_statew3(new_statew3), .new_statew4(new_statew4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (done && prev_done) dbl_cnt++;
        prev_done = done;
    end

    // Forward MixColumns, used to build round-trip stimulus
    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        fwd_mix = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Issue one request from IDLE; returns edges from acceptance to done (0 = timeout)
    task automatic run_op(input logic [31:0] a, b, c, d, output int lat);
        statew1 = a; statew2 = b; statew3 = c; statew4 = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++;
        if ({new_statew1, new_statew2, new_statew3, new_statew4} !== 128'h0) begin
            n_err++; $display("FAIL reset_outputs got=%h %h %h %h exp=0",
                              new_statew1, new_statew2, new_statew3, new_statew4);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int lat;
        run_op(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, lat);
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL single_latency got=%0d exp=5", lat); end
        n_vec++;
        if (new_statew1 !== 32'hdb135345 || new_statew2 !== 32'hdb135345 ||
            new_statew3 !== 32'hdb135345 || new_statew4 !== 32'hdb135345) begin
            n_err++; $display("FAIL single_result got=%h %h %h %h exp=db135345 x4",
                              new_statew1, new_statew2, new_statew3, new_statew4);
        end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL single_pulse_width got=%b exp=0", done); end
    endtask

    task automatic test_mixed;
        int lat;
        run_op(32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6, 32'h4d7ebdf8, lat);
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL mixed_latency got=%0d exp=5", lat); end
        n_vec++; if (new_statew1 !== 32'hf20a225c) begin n_err++; $display("FAIL mixed_w1 got=%h exp=f20a225c", new_statew1); end
        n_vec++; if (new_statew2 !== 32'h01010101) begin n_err++; $display("FAIL mixed_w2 got=%h exp=01010101", new_statew2); end
        n_vec++; if (new_statew3 !== 32'hd4d4d4d5) begin n_err++; $display("FAIL mixed_w3 got=%h exp=d4d4d4d5", new_statew3); end
        n_vec++; if (new_statew4 !== 32'h2d26314c) begin n_err++; $display("FAIL mixed_w4 got=%h exp=2d26314c", new_statew4); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_start_held;
        int base;
        base = done_cnt;
        statew1 = 32'hc6c6c6c6; statew2 = 32'hc6c6c6c6; statew3 = 32'hc6c6c6c6; statew4 = 32'hc6c6c6c6;
        start = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL held_one_pulse got=%0d exp=1", done_cnt - base); end
        n_vec++; if (new_statew3 !== 32'hc6c6c6c6) begin n_err++; $display("FAIL held_result got=%h exp=c6c6c6c6", new_statew3); end
        start = 1'b0;
        statew1 = 32'h9fdc589d;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL held_release got=%0d exp=1", done_cnt - base); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_vec++; if (done_cnt - base !== 2) begin n_err++; $display("FAIL held_second_pulse got=%0d exp=2", done_cnt - base); end
        n_vec++; if (new_statew1 !== 32'hf20a225c) begin n_err++; $display("FAIL held_second_w1 got=%h exp=f20a225c", new_statew1); end
    endtask

    task automatic test_busy_immunity;
        int base, lat;
        base = done_cnt;
        statew1 = 32'h8e4da1bc; statew2 = 32'h01010101; statew3 = 32'hd5d5d7d6; statew4 = 32'h8e4da1bc;
        start = 1'b1;
        @(posedge clk); #1;
        statew1 = 32'h12345678; statew2 = 32'hdeadbeef; statew3 = 32'h0badf00d; statew4 = 32'hffffffff;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            start = (k == 2 || k == 3) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (done && lat == 0) lat = k;
        end
        start = 1'b0;
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL busy_latency got=%0d exp=5", lat); end
        n_vec++;
        if (new_statew1 !== 32'hdb135345 || new_statew2 !== 32'h01010101 ||
            new_statew3 !== 32'hd4d4d4d5 || new_statew4 !== 32'hdb135345) begin
            n_err++; $display("FAIL busy_result got=%h %h %h %h exp=db135345 01010101 d4d4d4d5 db135345",
                              new_statew1, new_statew2, new_statew3, new_statew4);
        end
        n_vec++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL busy_extra_done got=%0d exp=1", done_cnt - base); end
    endtask

    task automatic test_reset_mid;
        int base, lat;
        base = done_cnt;
        statew1 = 32'h9fdc589d; statew2 = 32'h9fdc589d; statew3 = 32'h9fdc589d; statew4 = 32'h9fdc589d;
        start = 1'b1;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        @(posedge clk); #1;               // E1
        rst = 1'b1;
        @(posedge clk); #1;               // E2 under reset
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_vec++; if (done_cnt - base !== 0) begin n_err++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - base); end
        n_vec++;
        if ({new_statew1, new_statew2, new_statew3, new_statew4} !== 128'h0) begin
            n_err++; $display("FAIL rstmid_outputs got=%h %h %h %h exp=0",
                              new_statew1, new_statew2, new_statew3, new_statew4);
        end
        // start coincident with reset must not be accepted
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_vec++; if (done_cnt - base !== 0) begin n_err++; $display("FAIL rst_blocks_start got=%0d exp=0", done_cnt - base); end
        run_op(32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, lat);
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL rstmid_next_latency got=%0d exp=5", lat); end
        n_vec++;
        if (new_statew1 !== 32'hc6c6c6c6 || new_statew4 !== 32'hc6c6c6c6) begin
            n_err++; $display("FAIL rstmid_next_result got=%h %h exp=c6c6c6c6", new_statew1, new_statew4);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_round_trip;
        logic [31:0] orig [0:3];
        int lat;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 4; i++) orig[i] = $urandom;
            run_op(fwd_mix(orig[0]), fwd_mix(orig[1]), fwd_mix(orig[2]), fwd_mix(orig[3]), lat);
            n_vec++; if (lat !== 5) begin n_err++; $display("FAIL rt_latency[%0d] got=%0d exp=5", t, lat); end
            n_vec++; if (new_statew1 !== orig[0]) begin n_err++; $display("FAIL rt_w1[%0d] got=%h exp=%h", t, new_statew1, orig[0]); end
            n_vec++; if (new_statew2 !== orig[1]) begin n_err++; $display("FAIL rt_w2[%0d] got=%h exp=%h", t, new_statew2, orig[1]); end
            n_vec++; if (new_statew3 !== orig[2]) begin n_err++; $display("FAIL rt_w3[%0d] got=%h exp=%h", t, new_statew3, orig[2]); end
            n_vec++; if (new_statew4 !== orig[3]) begin n_err++; $display("FAIL rt_w4[%0d] got=%h exp=%h", t, new_statew4, orig[3]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pulse_width;
        n_vec++; if (dbl_cnt !== 0) begin n_err++; $display("FAIL done_back_to_back got=%0d exp=0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mixed();
        test_start_held();
        test_busy_immunity();
        test_reset_mid();
        test_round_trip();
        test_pulse_width();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
